// File: rtl/sample_fifo_if.sv
// Handshake bundle between a DSP stage and the multi-channel sample FIFO.
interface sample_fifo_if #(
  parameter int PKT_WIDTH = 16,
  parameter int NUM_CH    = 2,
  parameter int DEPTH     = 8
);
  localparam int FW = NUM_CH * PKT_WIDTH;
  localparam int LW = $clog2(DEPTH + 1);

  logic [FW-1:0]     pkt_i;
  logic              wrEN_i;
  logic              rdEN_i;
  logic              clrErr_i;
  logic [FW-1:0]     pktOut_s_o;
  logic              empty_o;
  logic              full_o;
  logic [LW-1:0]     level_o;
  logic [NUM_CH-1:0] pktOutChanged_s_o;
  logic              overflow_s_o;
  logic              underflow_s_o;

  modport master (
    output pkt_i, wrEN_i, rdEN_i, clrErr_i,
    input  pktOut_s_o, empty_o, full_o, level_o,
    input  pktOutChanged_s_o, overflow_s_o, underflow_s_o
  );

  modport slave (
    input  pkt_i, wrEN_i, rdEN_i, clrErr_i,
    output pktOut_s_o, empty_o, full_o, level_o,
    output pktOutChanged_s_o, overflow_s_o, underflow_s_o
  );
endinterface

// File: rtl/sample_fifo.sv
// FWFT multi-channel sample FIFO with overflow policy and change strobes.
module sample_fifo #(
  parameter int PKT_WIDTH   = 16,
  parameter int NUM_CH      = 2,
  parameter int DEPTH       = 8,
  parameter int DROP_OLDEST = 0
) (
  input logic         clk_i,
  input logic         rst_n_i,
  sample_fifo_if.slave bus
);
  localparam int FW = NUM_CH * PKT_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam bit DROP = (DROP_OLDEST != 0);

  logic [FW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic [FW-1:0]     last;
  logic [FW-1:0]     head;
  logic [NUM_CH-1:0] changed;
  logic [NUM_CH-1:0] diff;
  logic              ovf;
  logic              udf;
  logic              empty;
  logic              full;
  logic              do_push;
  logic              do_pop;
  logic              ovf_evt;
  logic              udf_evt;
  logic              drop;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign head  = mem[rd_ptr];

  // A full FIFO still accepts a push when a pop frees the slot.
  assign do_pop  = bus.rdEN_i & ~empty;
  assign do_push = bus.wrEN_i & (~full | bus.rdEN_i);
  assign ovf_evt = bus.wrEN_i & full & ~bus.rdEN_i;
  assign udf_evt = bus.rdEN_i & empty;
  assign drop    = ovf_evt & DROP;

  always_comb begin
    diff = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      diff[c] = head[c*PKT_WIDTH +: PKT_WIDTH]
             != last[c*PKT_WIDTH +: PKT_WIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push | drop) begin
      mem[wr_ptr] <= bus.pkt_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      last    <= '0;
      changed <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      if (do_push | drop) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop | drop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level   <= level + LW'(do_push) - LW'(do_pop);
      changed <= do_pop ? diff : '0;
      if (do_pop) begin
        last <= head;
      end
      ovf <= ovf_evt | (ovf & ~bus.clrErr_i);
      udf <= udf_evt | (udf & ~bus.clrErr_i);
    end
  end

  assign bus.pktOut_s_o        = empty ? last : head;
  assign bus.empty_o           = empty;
  assign bus.full_o            = full;
  assign bus.level_o           = level;
  assign bus.pktOutChanged_s_o = changed;
  assign bus.overflow_s_o      = ovf;
  assign bus.underflow_s_o     = udf;
endmodule

// File: tb/tb_sample_fifo.sv
// Bench for sample_fifo: both overflow policies driven in lockstep
// against a queue-based reference model.
module tb_sample_fifo;
  localparam int PW = 16;
  localparam int NC = 2;
  localparam int D  = 8;
  localparam int FW = 32;

  localparam logic [31:0] F1 [3] = '{
    32'h0001_0002, 32'h0003_0002, 32'h0003_0004};
  localparam logic [1:0] C1 [3] = '{2'b11, 2'b10, 2'b01};
  localparam logic [31:0] EA [8] = '{
    32'h1000_0002, 32'h1000_0003, 32'h1000_0004, 32'h1000_0005,
    32'h1000_0006, 32'h1000_0007, 32'h1000_0008, 32'hBBBB_0001};
  localparam logic [31:0] EB [8] = '{
    32'h1000_0003, 32'h1000_0004, 32'h1000_0005, 32'h1000_0006,
    32'h1000_0007, 32'h1000_0008, 32'hAAAA_AAAA, 32'hBBBB_0001};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic          clr = 1'b0;
  logic [FW-1:0] pkt = '0;
  int            checks = 0;
  int            failures = 0;
  bit            started = 1'b0;

  always #5 clk = ~clk;

  sample_fifo_if #(.PKT_WIDTH(PW), .NUM_CH(NC), .DEPTH(D)) a_if ();
  sample_fifo_if #(.PKT_WIDTH(PW), .NUM_CH(NC), .DEPTH(D)) b_if ();

  assign a_if.pkt_i    = pkt;
  assign a_if.wrEN_i   = wr;
  assign a_if.rdEN_i   = rd;
  assign a_if.clrErr_i = clr;
  assign b_if.pkt_i    = pkt;
  assign b_if.wrEN_i   = wr;
  assign b_if.rdEN_i   = rd;
  assign b_if.clrErr_i = clr;

  sample_fifo #(
    .PKT_WIDTH(PW), .NUM_CH(NC), .DEPTH(D), .DROP_OLDEST(0)
  ) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .bus(a_if.slave)
  );

  sample_fifo #(
    .PKT_WIDTH(PW), .NUM_CH(NC), .DEPTH(D), .DROP_OLDEST(1)
  ) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .bus(b_if.slave)
  );

  logic [FW-1:0] mq [2][$];
  logic [FW-1:0] last_m [2];
  logic [NC-1:0] chg_m [2];
  logic          ovf_m [2];
  logic          udf_m [2];
  int            mn;
  logic [FW-1:0] mh;
  logic          moe;

  initial begin
    for (int p = 0; p < 2; p++) begin
      last_m[p] = '0;
      chg_m[p]  = '0;
      ovf_m[p]  = 1'b0;
      udf_m[p]  = 1'b0;
    end
  end

  // Reference: index 0 discards on overflow, index 1 overwrites oldest.
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (!rst_n) begin
        mq[p].delete();
        last_m[p] = '0;
        chg_m[p]  = '0;
        ovf_m[p]  = 1'b0;
        udf_m[p]  = 1'b0;
      end else begin
        mn = mq[p].size();
        chg_m[p] = '0;
        moe = 1'b0;
        if (rd && mn > 0) begin
          mh = mq[p].pop_front();
          for (int c = 0; c < NC; c++) begin
            chg_m[p][c] = mh[c*PW +: PW] != last_m[p][c*PW +: PW];
          end
          last_m[p] = mh;
        end
        if (wr) begin
          if (mn < D || rd) begin
            mq[p].push_back(pkt);
          end else begin
            moe = 1'b1;
            if (p == 1) begin
              void'(mq[p].pop_front());
              mq[p].push_back(pkt);
            end
          end
        end
        ovf_m[p] = moe | (ovf_m[p] & ~clr);
        udf_m[p] = (rd && mn == 0) | (udf_m[p] & ~clr);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp(int p, logic [31:0] o, logic e, logic f,
                     logic [3:0] l, logic [1:0] c, logic ov, logic ud);
    int n = mq[p].size();
    string s = (p == 1) ? "b" : "a";
    chk({s, ".pkt"}, o, (n > 0) ? mq[p][0] : last_m[p]);
    chk({s, ".empty"}, 32'(e), 32'(n == 0));
    chk({s, ".full"}, 32'(f), 32'(n == D));
    chk({s, ".level"}, 32'(l), 32'(n));
    chk({s, ".chg"}, 32'(c), 32'(chg_m[p]));
    chk({s, ".ovf"}, 32'(ov), 32'(ovf_m[p]));
    chk({s, ".udf"}, 32'(ud), 32'(udf_m[p]));
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp(0, a_if.pktOut_s_o, a_if.empty_o, a_if.full_o, a_if.level_o,
          a_if.pktOutChanged_s_o, a_if.overflow_s_o, a_if.underflow_s_o);
      cmp(1, b_if.pktOut_s_o, b_if.empty_o, b_if.full_o, b_if.level_o,
          b_if.pktOutChanged_s_o, b_if.overflow_s_o, b_if.underflow_s_o);
    end
  end

  task automatic drive(logic w, logic r, logic c, logic [31:0] p);
    wr  = w;
    rd  = r;
    clr = c;
    pkt = p;
    @(posedge clk);
    #1;
    wr  = 1'b0;
    rd  = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    logic [31:0] s;
    #1;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    rst_n = 1'b1;
    started = 1'b1;
    chk("rst.empty", 32'(a_if.empty_o), 1);
    chk("rst.full", 32'(a_if.full_o), 0);
    chk("rst.level", 32'(a_if.level_o), 0);
    chk("rst.pkt", a_if.pktOut_s_o, 0);

    for (int i = 0; i < 3; i++) drive(1, 0, 0, F1[i]);
    chk("t1.level", 32'(a_if.level_o), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1.head", a_if.pktOut_s_o, F1[i]);
      drive(0, 1, 0, 0);
      chk("t1.chg", 32'(a_if.pktOutChanged_s_o), 32'(C1[i]));
    end
    chk("t1.empty", 32'(a_if.empty_o), 1);
    chk("t1.last", a_if.pktOut_s_o, 32'h0003_0004);

    for (int i = 1; i <= 8; i++) drive(1, 0, 0, 32'h1000_0000 + i);
    chk("t2.full", 32'(a_if.full_o), 1);
    chk("t2.level", 32'(a_if.level_o), 8);
    drive(1, 0, 0, 32'hAAAA_AAAA);
    chk("t2.a.level", 32'(a_if.level_o), 8);
    chk("t2.a.head", a_if.pktOut_s_o, 32'h1000_0001);
    chk("t2.a.ovf", 32'(a_if.overflow_s_o), 1);
    chk("t2.b.level", 32'(b_if.level_o), 8);
    chk("t2.b.head", b_if.pktOut_s_o, 32'h1000_0002);
    chk("t2.b.ovf", 32'(b_if.overflow_s_o), 1);
    drive(0, 0, 1, 0);
    chk("t2.clr", 32'(a_if.overflow_s_o), 0);
    drive(1, 1, 0, 32'hBBBB_0001);
    chk("t3.level", 32'(a_if.level_o), 8);
    chk("t3.ovf", 32'(a_if.overflow_s_o), 0);
    for (int i = 0; i < 8; i++) begin
      chk("t3.a.order", a_if.pktOut_s_o, EA[i]);
      chk("t3.b.order", b_if.pktOut_s_o, EB[i]);
      drive(0, 1, 0, 0);
    end
    chk("t3.empty", 32'(a_if.empty_o), 1);

    drive(1, 1, 0, 32'h5555_6666);
    chk("t4.level", 32'(a_if.level_o), 1);
    chk("t4.udf", 32'(a_if.underflow_s_o), 1);
    chk("t4.head", a_if.pktOut_s_o, 32'h5555_6666);
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 0);
    chk("t4.clr_hold", 32'(a_if.underflow_s_o), 1);
    drive(0, 0, 1, 0);
    chk("t4.clr", 32'(a_if.underflow_s_o), 0);

    s = 32'hC000_0000;
    drive(1, 0, 0, s);
    for (int i = 0; i < 20; i++) begin
      chk("t5.head", a_if.pktOut_s_o, s);
      s = s + 32'h0001_0003;
      drive(1, 1, 0, s);
      chk("t5.level", 32'(a_if.level_o), 1);
    end
    drive(0, 1, 0, 0);

    drive(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 32'h7000_0000 + i);
    chk("t6.level", 32'(a_if.level_o), 5);
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    chk("t6.empty", 32'(a_if.empty_o), 1);
    chk("t6.level0", 32'(a_if.level_o), 0);
    chk("t6.pkt", a_if.pktOut_s_o, 0);
    chk("t6.udf", 32'(a_if.underflow_s_o), 0);
    chk("t6.ovf", 32'(b_if.overflow_s_o), 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
